// File: rtl/serial_cmp_ctrl_if.sv
// Handshake and result bundle for the pairwise serial comparator.
// The master drives requests and the comparator drives status and results.
interface serial_cmp_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             busy;
  logic             done;
  logic             result;
  logic             alessb;
  logic             aeqb;
  logic             agrb;

  modport master (
    output start, a, b, op,
    input  busy, done, result, alessb, aeqb, agrb
  );

  modport slave (
    input  start, a, b, op,
    output busy, done, result, alessb, aeqb, agrb
  );
endinterface

// File: rtl/serial_cmp_ctrl.sv
// Serial magnitude comparator: walks captured operands two bits per cycle from
// the MSB pair down, stopping at the first differing pair.
//
// state | meaning
// IDLE  | waiting for start; results from the last completion are held
// RUN   | examining pair idx_q of the captured operands, one pair per cycle
module serial_cmp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  serial_cmp_ctrl_if.slave bus
);
  localparam int NPAIR = WIDTH / 2;
  localparam int IDXW  = (NPAIR > 1) ? $clog2(NPAIR) : 1;
  localparam logic [IDXW-1:0] IDX_MAX = IDXW'(NPAIR - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             done_q, done_d;
  logic             result_q, result_d;
  logic             alessb_q, alessb_d;
  logic             aeqb_q, aeqb_d;
  logic             agrb_q, agrb_d;

  logic [1:0] pair_a;
  logic [1:0] pair_b;

  assign pair_a = 2'(a_q >> {idx_q, 1'b0});
  assign pair_b = 2'(b_q >> {idx_q, 1'b0});

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    result_d = result_q;
    alessb_d = alessb_q;
    aeqb_d   = aeqb_q;
    agrb_d   = agrb_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.op;
          idx_d   = IDX_MAX;
          state_d = RUN;
        end
      end
      RUN: begin
        // Finish on the first differing pair, or after the LSB pair if all equal.
        if ((pair_a != pair_b) || (idx_q == '0)) begin
          alessb_d = (pair_a < pair_b);
          agrb_d   = (pair_a > pair_b);
          aeqb_d   = (pair_a == pair_b);
          unique case (op_q)
            2'b00: result_d = alessb_d;
            2'b01: result_d = agrb_d;
            2'b10: result_d = aeqb_d;
            2'b11: result_d = !aeqb_d;
          endcase
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      result_q <= 1'b0;
      alessb_q <= 1'b0;
      aeqb_q   <= 1'b0;
      agrb_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      result_q <= result_d;
      alessb_q <= alessb_d;
      aeqb_q   <= aeqb_d;
      agrb_q   <= agrb_d;
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.alessb = alessb_q;
  assign bus.aeqb   = aeqb_q;
  assign bus.agrb   = agrb_q;
endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Directed and randomized checks of serial_cmp_ctrl against an arithmetic
// reference model of comparison outcome and pair-walk latency.
module tb_serial_cmp_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  bit exp_lt, exp_gt, exp_eq, exp_res;

  serial_cmp_ctrl_if #(.WIDTH(W)) bus();

  serial_cmp_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pairs examined up to and including the first differing one, MSB first.
  function automatic int model_lat(input int av, input int bv);
    for (int k = 1; k <= W / 2; k++) begin
      int sh;
      sh = W - 2 * k;
      if (((av >> sh) % 4) != ((bv >> sh) % 4)) return k;
    end
    return W / 2;
  endfunction

  function automatic bit model_res(input int av, input int bv, input int opv);
    case (opv)
      0: return av < bv;
      1: return av > bv;
      2: return av == bv;
      default: return av != bv;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch a comparison from an IDLE-accepting cycle and follow it to done.
  // mode 1: scramble inputs after accept; mode 2: also pulse start mid-run.
  task automatic do_cmp(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [1:0] top, input int mode);
    int lat;
    int k;
    k       = model_lat(int'(ta), int'(tb_v));
    exp_lt  = (ta < tb_v);
    exp_gt  = (ta > tb_v);
    exp_eq  = (ta == tb_v);
    exp_res = model_res(int'(ta), int'(tb_v), int'(top));
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_v;
    bus.op    = top;
    step();
    bus.start = 1'b0;
    if (mode != 0) begin
      bus.a  = 8'($urandom);
      bus.b  = 8'($urandom);
      bus.op = 2'($urandom);
    end
    lat = 0;
    do begin
      chk({tag, "_busy"}, bus.busy, 1);
      chk({tag, "_done_low"}, bus.done, 0);
      if (mode == 2 && lat == 1) begin
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'h00;
      end else begin
        bus.start = 1'b0;
      end
      step();
      lat++;
    end while (!bus.done && lat < 20);
    bus.start = 1'b0;
    chk({tag, "_latency"}, lat, k);
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_busy_end"}, bus.busy, 0);
    chk({tag, "_alessb"}, bus.alessb, exp_lt);
    chk({tag, "_agrb"}, bus.agrb, exp_gt);
    chk({tag, "_aeqb"}, bus.aeqb, exp_eq);
    chk({tag, "_result"}, bus.result, exp_res);
  endtask

  task automatic hold_check(input string tag);
    step();
    chk({tag, "_pulse_end"}, bus.done, 0);
    chk({tag, "_hold_busy"}, bus.busy, 0);
    chk({tag, "_hold_flags"}, {bus.alessb, bus.agrb, bus.aeqb, bus.result},
        {exp_lt, exp_gt, exp_eq, exp_res});
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.op    = '0;
    step();
    step();
    chk("rst_outputs", {bus.busy, bus.done, bus.result, bus.alessb, bus.aeqb, bus.agrb}, 6'b0);
    reset = 1'b0;
    step();
    chk("rst_idle", {bus.busy, bus.done}, 2'b0);

    do_cmp("eq3c", 8'h3C, 8'h3C, 2'b10, 0);
    hold_check("eq3c");
    do_cmp("gt80", 8'h80, 8'h7F, 2'b00, 0);
    hold_check("gt80");
    do_cmp("lt12", 8'h12, 8'h13, 2'b00, 0);
    hold_check("lt12");
    do_cmp("ne12", 8'h12, 8'h13, 2'b11, 0);
    hold_check("ne12");
    do_cmp("ign_start", 8'h12, 8'h13, 2'b00, 2);
    hold_check("ign_start");

    // Abort an in-flight comparison with reset.
    bus.start = 1'b1;
    bus.a     = 8'h3C;
    bus.b     = 8'h3C;
    bus.op    = 2'b10;
    step();
    bus.start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_outputs", {bus.busy, bus.done, bus.result, bus.alessb, bus.aeqb, bus.agrb}, 6'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_no_done", {bus.busy, bus.done}, 2'b0);
    end
    do_cmp("post_rst", 8'h01, 8'h00, 2'b01, 0);
    hold_check("post_rst");

    // Back-to-back: next start is driven in the done cycle.
    do_cmp("b2b_first", 8'h12, 8'h13, 2'b00, 0);
    do_cmp("b2b_second", 8'h40, 8'h00, 2'b01, 0);
    hold_check("b2b_second");

    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ 8'(1 << $urandom_range(0, 7));
        default: rb = 8'($urandom);
      endcase
      do_cmp("rand", ra, rb, 2'($urandom), int'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) hold_check("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_cmp_ctrl.md
SERIAL_CMP_CTRL -- requirements
Module: serial_cmp_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; WIDTH SHALL be even and at least 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a new comparison.
REQ-005 The block SHALL have port a, input, WIDTH bits: first operand, unsigned.
REQ-006 The block SHALL have port b, input, WIDTH bits: second operand, unsigned.
REQ-007 The block SHALL have port op, input, 2 bits: requested relation; 00 = a<b, 01 = a>b, 10 = a==b, 11 = a!=b.
REQ-008 The block SHALL have port busy, output, 1 bit: comparison in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking valid results.
REQ-010 The block SHALL have port result, output, 1 bit: truth of the captured op relation.
REQ-011 The block SHALL have ports alessb, aeqb and agrb, outputs, 1 bit each: relation flags for the last completed comparison.

Function
REQ-012 The block SHALL implement two states: IDLE and RUN; busy = (state == RUN).
REQ-013 In IDLE with start=1 at a clock edge, the block SHALL capture a, b and op into internal registers, set pair index to WIDTH/2-1 and enter RUN.
REQ-014 The block SHALL ignore start while in RUN; captured operands and op SHALL NOT change until the comparison completes.
REQ-015 In RUN, the block SHALL compare one 2-bit pair per cycle, taking captured bits [2i+1:2i] at index i, from MSB pair toward LSB pair.
REQ-016 On a pair with a>b, the block SHALL set agrb=1, alessb=0, aeqb=0, pulse done and return to IDLE at that edge.
REQ-017 On a pair with a<b, the block SHALL set alessb=1, agrb=0, aeqb=0, pulse done and return to IDLE at that edge.
REQ-018 On an equal pair with i>0, the block SHALL decrement i and remain in RUN.
REQ-019 On an equal pair with i=0, the block SHALL set aeqb=1, alessb=0, agrb=0, pulse done and return to IDLE.
REQ-020 Latency: done SHALL be high exactly k cycles after the start-accept edge, where k (1..WIDTH/2) is the number of pairs examined up to and including the first differing pair, or WIDTH/2 if all pairs are equal.
REQ-021 The block SHALL assert done for exactly one cycle per accepted start.
REQ-022 result SHALL be updated in the same edge as done, from the captured op: alessb, agrb, aeqb or !aeqb respectively.
REQ-023 result, alessb, aeqb and agrb SHALL hold their values from done until the next completion; after the first completion exactly one flag SHALL be high.
REQ-024 A start asserted in the cycle done is high SHALL be accepted, since state is IDLE, giving back-to-back operation with no dead cycle.
REQ-025 Operand or op input changes after the accept edge SHALL NOT affect the in-flight comparison.

Reset
REQ-026 reset=1 at a clock edge SHALL force state to IDLE and drive busy=0, done=0, result=0, alessb=0, aeqb=0, agrb=0, with the pair index cleared.
REQ-027 reset SHALL take priority over start and over any RUN-state transition; an in-flight comparison SHALL be aborted with no done pulse.
REQ-028 After reset deasserts, the first start in IDLE SHALL be accepted normally.

Verification (WIDTH=8)
REQ-029 The bench SHALL drive a=0x3C, b=0x3C, op=10 -> busy for 4 cycles; done in cycle 4 with aeqb=1 and result=1.
REQ-030 The bench SHALL drive a=0x80, b=0x7F, op=00 -> done in cycle 1 with agrb=1 and result=0.
REQ-031 The bench SHALL drive a=0x12, b=0x13, op=00 -> done in cycle 4 with alessb=1 and result=1; the same operands with op=11 -> result=1.
REQ-032 The bench SHALL start a=0x12, b=0x13, then pulse start with a=0xFF, b=0x00 in cycle 2 -> the second start is ignored; done in cycle 4 with alessb=1.
REQ-033 The bench SHALL start a=0x3C, b=0x3C and assert reset in cycle 2 -> no done pulse; all outputs are 0 next cycle; a later start with a=0x01, b=0x00, op=01 -> done in cycle 4, result=1.
REQ-034 The bench SHALL assert start with a=0x40, b=0x00, op=01 in the done cycle of a prior comparison -> accepted; done 1 cycle later with agrb=1 and result=1.
